keypad_entry_ctrl: RTL and testbench
====================================

Name: keypad_entry_ctrl

Overview:
- Sequences operator code entry on the 4x4 matrix keypad.
- Consumes one decoded key event per debounced press from the column scanner.
- Enforces press/release locking and places digits into positional registers reg1..reg4. Handles '*' clear, 'D' backspace and '#' confirm, and discards stale entries after an inactivity timeout.
- Sits between the keypad scanner and the code-checking logic.

Parameters:
- TIMEOUT_CYC, 50000000: inactivity limit in clk cycles. Once entry has started, this many cycles without an accepted key clear the entry. Must be at least 2.
- TMR_W, 26: width of the inactivity counter. Must satisfy 2^TMR_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- key_valid  in  1  one-cycle pulse from the scanner: a decoded press is available on key_code.
- key_code  in  4  key code: 0x0-0x9 digits; 0xA/0xB/0xC letters; 0xD backspace; 0xE '*'; 0xF '#'.
- key_held  in  1  level from the scanner: high while any key is physically down.
- reg1  out  4  first digit entered (BCD).
- reg2  out  4  second digit entered.
- reg3  out  4  third digit entered.
- reg4  out  4  fourth digit entered.
- digit_count  out  3  number of digits currently held, 0..4.
- code_valid  out  1  one-cycle pulse: a confirmed code is presented on code_value/code_len.
- code_value  out  16  {reg1,reg2,reg3,reg4} captured at confirm; unused positions read 0.
- code_len  out  3  digit count captured at confirm, 1..4.
- entry_err  out  1  one-cycle pulse on a rejected key.
- timeout  out  1  one-cycle pulse when the inactivity timeout clears the entry.

Behaviour:
- Reset: all outputs are 0 after the first rising edge with rst=1, and the FSM is in EMPTY. The lock flag and timer are cleared. rst mid-entry discards the partial code and emits no pulse.
- All outputs are registered. A key sampled at edge N is reflected in the outputs after edge N, i.e. one cycle of latency. Pulses last exactly one cycle.
- Lock: a key is accepted only when key_valid=1 and lock=0. Acceptance sets lock. lock clears on any edge where key_held=0. While locked, key_valid is ignored silently, with no entry_err.
- FSM states and what they hold:
  - EMPTY: digit_count=0.
  - ENTRY: digit_count 1..3.
  - FULL: digit_count=4.
- Accepted digit (0x0-0x9):
  - In EMPTY or ENTRY, the digit is written to reg[digit_count+1] and digit_count increments.
  - EMPTY goes to ENTRY; a count of 3 goes to FULL.
  - In FULL the digit is rejected: entry_err pulses and the state is unchanged.
- 0xE '*': clears reg1..reg4 and digit_count, then goes to EMPTY. This is valid in any state, with no error.
- 0xD backspace:
  - In ENTRY or FULL, the register at position digit_count is cleared and digit_count decrements.
  - FULL goes to ENTRY; a count of 1 goes to EMPTY.
  - In EMPTY, entry_err pulses.
- 0xF '#':
  - In ENTRY or FULL, code_value and code_len are loaded from the current regs and count, and code_valid pulses in the same cycle.
  - reg1..reg4 and digit_count clear, and the FSM goes to EMPTY.
  - In EMPTY, entry_err pulses.
- 0xA/0xB/0xC: ignored. They set lock, but cause no state change and no error.
- code_value and code_len hold their values until the next confirm or reset.
- Timer:
  - Runs only in ENTRY or FULL, and reloads to 0 on every accepted key.
  - When the timer reaches TIMEOUT_CYC-1 with no key accepted that cycle, the regs and count are cleared, the FSM goes to EMPTY and timeout pulses.
  - Simultaneous accepted key and expiry: the key wins, is processed normally, and the timer reloads.
  - In EMPTY the timer is held at 0.

Test Plan:
- Scenario 1 (basic confirm):
  - Stimulus: after rst, press/release 1,2,3,4 then '#', each with key_held dropping between presses.
  - Response: reg1..4=1,2,3,4 and digit_count=4 before '#'. Then code_valid pulses once with code_value=0x1234, code_len=4, and digit_count returns to 0.
- Scenario 2 (lock and short codes):
  - Stimulus: press 7 with key_valid pulsed twice while key_held stays high.
  - Response: only one digit is accepted (digit_count=1, reg1=7), with no entry_err.
  - Follow-on stimulus: '#' then yields code_value=0x7000, code_len=1.
- Scenario 3 (editing):
  - Stimulus: enter 5,6, backspace, 9, '*'.
  - Response: after the backspace, reg2=0 and digit_count=1; after 9, reg2=9. '*' clears all regs and count with no pulses.
- Scenario 4 (errors):
  - Stimulus: '#' in EMPTY; backspace in EMPTY; a fifth digit in FULL.
  - Response: each produces an entry_err pulse and leaves the state unchanged. 0xB in any state produces nothing.
- Scenario 5 (timeout), with TIMEOUT_CYC=8:
  - Stimulus: enter 3, then idle.
  - Response: timeout pulses exactly 8 cycles after acceptance and digit_count=0.
  - Repeat stimulus: this time a key is accepted on the expiry cycle.
  - Response: no timeout, the key is processed and the timer restarts.
- Scenario 6 (reset mid-entry):
  - Stimulus: assert rst mid-entry with digit_count=3.
  - Response: the next cycle shows all outputs 0 and no code_valid.

Source files
------------

// File: rtl/keypad_entry_if.sv
// Key-event and entry-result bundle between the keypad scanner/checker side
// (master) and keypad_entry_ctrl (slave).
interface keypad_entry_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic [3:0]  reg1;
  logic [3:0]  reg2;
  logic [3:0]  reg3;
  logic [3:0]  reg4;
  logic [2:0]  digit_count;
  logic        code_valid;
  logic [15:0] code_value;
  logic [2:0]  code_len;
  logic        entry_err;
  logic        timeout;

  modport master (
    output key_valid, key_code, key_held,
    input  reg1, reg2, reg3, reg4, digit_count,
    input  code_valid, code_value, code_len, entry_err, timeout
  );

  modport slave (
    input  key_valid, key_code, key_held,
    output reg1, reg2, reg3, reg4, digit_count,
    output code_valid, code_value, code_len, entry_err, timeout
  );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// Keypad code-entry sequencer: press locking, up to four positional digits,
// clear/backspace/confirm keys and an inactivity timeout.
module keypad_entry_ctrl #(
  parameter int TIMEOUT_CYC = 50000000,
  parameter int TMR_W       = 26
) (
  input  logic          clk,
  input  logic          rst,
  keypad_entry_if.slave kif
);

  typedef enum logic [1:0] {EMPTY, ENTRY, FULL} state_t;

  localparam logic [3:0] K_BS    = 4'hD;
  localparam logic [3:0] K_CLEAR = 4'hE;
  localparam logic [3:0] K_CONF  = 4'hF;

  state_t            state_q, state_d;
  logic [3:0]        regs_q [4];
  logic [3:0]        regs_d [4];
  logic [2:0]        cnt_q, cnt_d;
  logic              lock_q, lock_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              cv_q, cv_d;
  logic [15:0]       cval_q, cval_d;
  logic [2:0]        clen_q, clen_d;
  logic              err_q, err_d;
  logic              to_q, to_d;

  logic       accept;
  logic       is_digit;
  logic       expire;
  logic [1:0] wr_idx;
  logic [1:0] bs_idx;

  assign accept   = kif.key_valid & ~lock_q;
  assign is_digit = (kif.key_code <= 4'd9);
  // Expiry only matters while an entry is in progress; the timer sits at 0 in EMPTY.
  assign expire   = (state_q != EMPTY) && (tmr_q == TMR_W'(TIMEOUT_CYC - 1));
  assign wr_idx   = cnt_q[1:0];
  assign bs_idx   = cnt_q[1:0] - 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      for (int i = 0; i < 4; i++) regs_q[i] <= 4'd0;
      cnt_q   <= 3'd0;
      lock_q  <= 1'b0;
      tmr_q   <= '0;
      cv_q    <= 1'b0;
      cval_q  <= 16'd0;
      clen_q  <= 3'd0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
      cnt_q   <= cnt_d;
      lock_q  <= lock_d;
      tmr_q   <= tmr_d;
      cv_q    <= cv_d;
      cval_q  <= cval_d;
      clen_q  <= clen_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (is_digit) begin
        if (state_q != FULL) state_d = (cnt_q == 3'd3) ? FULL : ENTRY;
      end else if (kif.key_code == K_CLEAR) begin
        state_d = EMPTY;
      end else if (kif.key_code == K_BS) begin
        if (state_q != EMPTY) state_d = (cnt_q == 3'd1) ? EMPTY : ENTRY;
      end else if (kif.key_code == K_CONF) begin
        state_d = EMPTY;
      end
    end else if (expire) begin
      state_d = EMPTY;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) regs_d[i] = regs_q[i];
    cnt_d  = cnt_q;
    cv_d   = 1'b0;
    cval_d = cval_q;
    clen_d = clen_q;
    err_d  = 1'b0;
    to_d   = 1'b0;
    tmr_d  = tmr_q;
    lock_d = lock_q;

    // Acceptance takes priority over a same-edge release so one press locks once.
    if (accept)             lock_d = 1'b1;
    else if (!kif.key_held) lock_d = 1'b0;

    if (accept) begin
      tmr_d = '0;
      if (is_digit) begin
        if (state_q == FULL) begin
          err_d = 1'b1;
        end else begin
          regs_d[wr_idx] = kif.key_code;
          cnt_d          = cnt_q + 3'd1;
        end
      end else if (kif.key_code == K_CLEAR) begin
        for (int i = 0; i < 4; i++) regs_d[i] = 4'd0;
        cnt_d = 3'd0;
      end else if (kif.key_code == K_BS) begin
        if (state_q == EMPTY) begin
          err_d = 1'b1;
        end else begin
          regs_d[bs_idx] = 4'd0;
          cnt_d          = cnt_q - 3'd1;
        end
      end else if (kif.key_code == K_CONF) begin
        if (state_q == EMPTY) begin
          err_d = 1'b1;
        end else begin
          cv_d   = 1'b1;
          cval_d = {regs_q[0], regs_q[1], regs_q[2], regs_q[3]};
          clen_d = cnt_q;
          for (int i = 0; i < 4; i++) regs_d[i] = 4'd0;
          cnt_d = 3'd0;
        end
      end
    end else if (expire) begin
      for (int i = 0; i < 4; i++) regs_d[i] = 4'd0;
      cnt_d = 3'd0;
      to_d  = 1'b1;
      tmr_d = '0;
    end else if (state_q == EMPTY) begin
      tmr_d = '0;
    end else begin
      tmr_d = tmr_q + TMR_W'(1);
    end
  end

  assign kif.reg1        = regs_q[0];
  assign kif.reg2        = regs_q[1];
  assign kif.reg3        = regs_q[2];
  assign kif.reg4        = regs_q[3];
  assign kif.digit_count = cnt_q;
  assign kif.code_valid  = cv_q;
  assign kif.code_value  = cval_q;
  assign kif.code_len    = clen_q;
  assign kif.entry_err   = err_q;
  assign kif.timeout     = to_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Scoreboard bench for keypad_entry_ctrl: directed scenarios followed by
// randomized key traffic, checked against a digit-queue reference model.
module tb_keypad_entry_ctrl;

  localparam int TO_CYC = 8;

  logic clk;
  logic rst;

  keypad_entry_if kif ();

  keypad_entry_ctrl #(.TIMEOUT_CYC(TO_CYC), .TMR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .kif (kif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] regs;
    logic [2:0]  cnt;
    logic        cv;
    logic [15:0] cval;
    logic [2:0]  clen;
    logic        err;
    logic        to;
  } snap_t;

  typedef struct packed {
    logic [15:0] val;
    logic [2:0]  len;
  } code_t;

  snap_t exp_q[$];
  code_t code_q[$];

  int total = 0;
  int bad   = 0;

  // Reference model: the entry is just an ordered list of digits.
  int          m_dig[$];
  bit          m_lock;
  int          m_idle;
  logic [15:0] m_cval;
  logic [2:0]  m_clen;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] pack_digits();
    logic [15:0] v = 16'd0;
    for (int i = 0; i < m_dig.size(); i++) v[15-4*i -: 4] = 4'(m_dig[i]);
    return v;
  endfunction

  task automatic model(input bit kv, input int kc, input bit kh, input bit r);
    snap_t s;
    code_t c;
    bit acc;
    s = '0;
    if (r) begin
      m_dig.delete();
      m_lock = 0; m_idle = 0; m_cval = 0; m_clen = 0;
    end else begin
      acc = kv && !m_lock;
      if (acc)      m_lock = 1;
      else if (!kh) m_lock = 0;
      if (acc) begin
        m_idle = 0;
        if (kc <= 9) begin
          if (m_dig.size() < 4) m_dig.push_back(kc);
          else s.err = 1;
        end else if (kc == 14) begin
          m_dig.delete();
        end else if (kc == 13) begin
          if (m_dig.size() > 0) void'(m_dig.pop_back());
          else s.err = 1;
        end else if (kc == 15) begin
          if (m_dig.size() > 0) begin
            m_cval = pack_digits();
            m_clen = 3'(m_dig.size());
            s.cv = 1;
            c.val = m_cval; c.len = m_clen;
            code_q.push_back(c);
            m_dig.delete();
          end else s.err = 1;
        end
      end else if (m_dig.size() > 0) begin
        if (m_idle == TO_CYC - 1) begin
          m_dig.delete();
          s.to = 1;
          m_idle = 0;
        end else m_idle++;
      end else m_idle = 0;
    end
    s.regs = pack_digits();
    s.cnt  = 3'(m_dig.size());
    s.cval = m_cval;
    s.clen = m_clen;
    exp_q.push_back(s);
  endtask

  task automatic step(input bit kv, input int kc, input bit kh, input bit r);
    @(negedge clk);
    kif.key_valid = kv;
    kif.key_code  = 4'(kc);
    kif.key_held  = kh;
    rst           = r;
    model(kv, kc, kh, r);
  endtask

  task automatic press(input int kc);
    step(1, kc, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  // Monitor: compares every registered output after each rising edge.
  always begin
    snap_t e;
    code_t c;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("reg1",        kif.reg1,        e.regs[15:12]);
      chk("reg2",        kif.reg2,        e.regs[11:8]);
      chk("reg3",        kif.reg3,        e.regs[7:4]);
      chk("reg4",        kif.reg4,        e.regs[3:0]);
      chk("digit_count", kif.digit_count, e.cnt);
      chk("code_valid",  kif.code_valid,  e.cv);
      chk("code_value",  kif.code_value,  e.cval);
      chk("code_len",    kif.code_len,    e.clen);
      chk("entry_err",   kif.entry_err,   e.err);
      chk("timeout",     kif.timeout,     e.to);
    end
    if (kif.code_valid === 1'b1) begin
      if (code_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL confirm_event actual=unexpected code_valid required=none at %0t", $time);
      end else begin
        c = code_q.pop_front();
        chk("confirm_value", kif.code_value, c.val);
        chk("confirm_len",   kif.code_len,   c.len);
      end
    end
  end

  initial begin
    rst           = 1'b1;
    kif.key_valid = 1'b0;
    kif.key_code  = 4'h0;
    kif.key_held  = 1'b0;

    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    idle(2);

    // Basic confirm
    press(1); press(2); press(3); press(4);
    press(15);
    idle(2);

    // Lock: second key_valid while held is ignored; short code
    step(1, 7, 1, 0);
    step(0, 0, 1, 0);
    step(1, 7, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    press(15);

    // Editing
    press(5); press(6); press(13); press(9); press(14);

    // Errors and ignored letter
    press(15); press(13); press(11);
    press(1); press(11); press(2); press(3); press(4); press(5); press(11);
    press(14);

    // Timeout: idle past the limit, then a key landing on the expiry cycle
    press(3);
    idle(8);
    press(3);
    idle(5);
    step(1, 5, 1, 0);
    step(0, 0, 0, 0);
    idle(12);

    // Reset mid-entry
    press(8); press(6); press(2);
    step(0, 0, 0, 1);
    idle(3);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      int kc;
      bit kv, kh, r;
      if ($urandom_range(0, 99) < 60) kc = $urandom_range(0, 9);
      else                            kc = $urandom_range(10, 15);
      kv = ($urandom_range(0, 99) < 30);
      kh = kv ? 1'b1 : ($urandom_range(0, 1) == 1);
      r  = ($urandom_range(0, 499) == 0);
      step(kv, kc, kh, r);
      if ($urandom_range(0, 99) == 0) idle($urandom_range(5, 12));
    end

    idle(3);
    @(posedge clk);
    #2;
    chk("pending_snapshots", exp_q.size(), 0);
    chk("pending_confirms",  code_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
